// File: rtl/ioblock_pkg.sv
// ioblock_pkg: shared TSMUX encodings, pin-block state type and counter sizing helper
// for the input and output I/O blocks.
`default_nettype none

package ioblock_pkg;

  localparam logic [1:0] TSMUX_HIZ = 2'b00;
  localparam logic [1:0] TSMUX_TS  = 2'b01;
  localparam logic [1:0] TSMUX_DRV = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ioblock_oser_if.sv
// ioblock_oser_if: fabric-side valid/ready word handshake into the output serialiser.
`default_nettype none

interface ioblock_oser_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] txd;
  logic             txvalid;
  logic             txready;

  modport master (output txd, output txvalid, input  txready);
  modport slave  (input  txd, input  txvalid, output txready);
endinterface

`default_nettype wire

// File: rtl/ioblock_tsdrv.sv
// ioblock_tsdrv: combinational tristate pin driver shared by the input and output I/O blocks.
`default_nettype none

module ioblock_tsdrv
  import ioblock_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       data,
  input  state_t     state,
  input  logic       ts,
  input  logic [1:0] cfg_tsmux,
  inout  wire        pin
);

  logic drive;
  logic level;

  always_comb begin
    level = (state == IDLE) ? IDLE_LEVEL : data;
    case (cfg_tsmux)
      TSMUX_HIZ: drive = 1'b0;
      TSMUX_TS:  drive = ts && (state != IDLE);
      default:   drive = 1'b1;
    endcase
  end

  assign pin = drive ? level : 1'bz;

endmodule

`default_nettype wire

// File: rtl/ioblock_oser.sv
// ioblock_oser: one-word buffered LSB-first serialiser onto a tristate pin.
// Define IOB_PARITY_EN to append an even-parity bit to every frame.
`default_nettype none

module ioblock_oser
  import ioblock_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             ioclk,
  input  logic             rst_n,
  ioblock_oser_if.slave    tx,
  inout  wire              pin,
  input  logic             ts,
  input  logic [1:0]       cfg_tsmux,
  output logic             busy,
  output logic             word_done
);

  localparam int             CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             accept;
  logic             last_edge;
  logic             load;
  logic             pin_data;
`ifdef IOB_PARITY_EN
  logic             par_q;
`endif

  assign accept = tx.txvalid && !hold_full;

  // The edge that closes a frame is where WORD_DONE fires and the hold buffer may reload.
  always_comb begin
`ifdef IOB_PARITY_EN
    last_edge = (state == PARITY);
    pin_data  = (state == PARITY) ? par_q : shift_q[0];
`else
    last_edge = (state == SHIFT) && (cnt == LAST_CNT);
    pin_data  = shift_q[0];
`endif
    load = hold_full && ((state == IDLE) || last_edge);
  end

  always_ff @(posedge ioclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      done_q    <= 1'b0;
`ifdef IOB_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      done_q <= last_edge;
      if (load) begin
        shift_q   <= hold_q;
        hold_full <= 1'b0;
        cnt       <= '0;
        state     <= SHIFT;
`ifdef IOB_PARITY_EN
        par_q     <= ^hold_q;
`endif
      end else begin
        // load requires hold_full, accept requires it clear, so they never coincide
        if (accept) begin
          hold_q    <= tx.txd;
          hold_full <= 1'b1;
        end
        case (state)
          SHIFT: begin
            shift_q <= shift_q >> 1;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
`ifdef IOB_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end
`ifdef IOB_PARITY_EN
          PARITY:  state <= IDLE;
`endif
          default: state <= state;
        endcase
      end
    end
  end

  assign tx.txready = !hold_full;
  assign busy       = (state != IDLE);
  assign word_done  = done_q;

  ioblock_tsdrv #(
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_tsdrv (
    .data      (pin_data),
    .state     (state),
    .ts        (ts),
    .cfg_tsmux (cfg_tsmux),
    .pin       (pin)
  );

endmodule

`default_nettype wire

// File: tb/tb_ioblock_oser.sv
// tb_ioblock_oser: randomized self-checking bench for ioblock_oser against a frame-timeline model.
`default_nettype none

module tb_ioblock_oser;

  localparam int W = 8;
`ifdef IOB_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ts = 1'b1;
  logic [1:0] cfg_tsmux = 2'b10;
  wire        pin;
  logic       busy;
  logic       word_done;
  logic       pin_z;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] words[$];

  ioblock_oser_if #(.WIDTH(W)) txif ();

  ioblock_oser #(
    .WIDTH      (W),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .ioclk     (clk),
    .rst_n     (rst_n),
    .tx        (txif.slave),
    .pin       (pin),
    .ts        (ts),
    .cfg_tsmux (cfg_tsmux),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  assign pin_z = (pin === 1'bz);

  // pin observation code: 0/1 driven level, 2 high impedance
  function automatic logic [1:0] pin_obs(input logic z, input logic v);
    return z ? 2'd2 : {1'b0, v};
  endfunction

  function automatic logic even_par(input logic [W-1:0] w);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n += int'(w[i]);
    return (n % 2) == 1;
  endfunction

  // Runs words[] through the DUT with TXVALID held while words remain; checks every cycle.
  task automatic run_stream(input string name, input logic [1:0] mode,
                            input int ts_lo, input int ts_hi);
    int         n;
    int         total;
    int         sent;
    bit         acc;
    logic       e_busy, e_done, e_ready, bitv;
    logic [1:0] e_pin, o_pin;
    n     = words.size();
    total = 2 + n * F + 3;
    sent  = 0;
    acc   = 1'b0;
    cfg_tsmux = mode;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (acc) sent++;
      if (mode == 2'b01 && ts_lo >= 0) ts = !(c >= 2 + ts_lo && c <= 2 + ts_hi);
      else if (mode == 2'b01)          ts = 1'b1;
      else                             ts = 1'($urandom % 2);
      #1;
      e_busy  = (c >= 2) && (c < 2 + n * F);
      e_done  = 1'b0;
      for (int j = 1; j <= n; j++) if (c == 2 + j * F) e_done = 1'b1;
      e_ready = 1'b1;
      for (int j = 0; j < n; j++) begin
        int a, l;
        a = (j == 0) ? 1 : 3 + (j - 1) * F;
        l = 2 + j * F;
        if (c >= a && c < l) e_ready = 1'b0;
      end
      bitv = 1'b0;
      if (e_busy) begin
        int j, b;
        j = (c - 2) / F;
        b = (c - 2) % F;
        bitv = (b < W) ? words[j][b] : even_par(words[j]);
      end
      if (mode == 2'b00)      e_pin = 2'd2;
      else if (mode == 2'b01) e_pin = (e_busy && ts) ? {1'b0, bitv} : 2'd2;
      else                    e_pin = e_busy ? {1'b0, bitv} : 2'd1;
      o_pin = pin_obs(pin_z, pin);

      checks++;
      if (o_pin !== e_pin) begin
        errors++;
        $display("FAIL %s pin cycle %0d: got %0d expected %0d (2=hi-z)", name, c, o_pin, e_pin);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, e_busy);
      end
      checks++;
      if (word_done !== e_done) begin
        errors++;
        $display("FAIL %s word_done cycle %0d: got %b expected %b", name, c, word_done, e_done);
      end
      checks++;
      if (txif.txready !== e_ready) begin
        errors++;
        $display("FAIL %s txready cycle %0d: got %b expected %b", name, c, txif.txready, e_ready);
      end

      if (sent < n) begin
        txif.txvalid = 1'b1;
        txif.txd     = words[sent];
      end else begin
        txif.txvalid = 1'b0;
        txif.txd     = W'($urandom);
      end
      acc = txif.txvalid && txif.txready;
    end
    txif.txvalid = 1'b0;
    ts = 1'b1;
  endtask

  task automatic check_idle(input string name, input logic [1:0] e_pin);
    logic [1:0] o_pin;
    o_pin = pin_obs(pin_z, pin);
    checks++;
    if (o_pin !== e_pin) begin
      errors++;
      $display("FAIL %s pin: got %0d expected %0d (2=hi-z)", name, o_pin, e_pin);
    end
    checks++;
    if (txif.txready !== 1'b1 || busy !== 1'b0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL %s status: got ready=%b busy=%b done=%b expected 1 0 0",
               name, txif.txready, busy, word_done);
    end
  endtask

  task automatic test_reset();
    txif.txvalid = 1'b0;
    txif.txd     = '0;
    rst_n        = 1'b0;
    cfg_tsmux    = 2'b10;
    #2;
    check_idle("reset_drv", 2'd1);
    cfg_tsmux = 2'b00;
    #1;
    check_idle("reset_hiz", 2'd2);
    cfg_tsmux = 2'b01;
    ts = 1'b1;
    #1;
    check_idle("reset_ts", 2'd2);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_tsmux = 2'b10;
    repeat (2) @(negedge clk);
    #1;
    check_idle("after_reset", 2'd1);
  endtask

  task automatic test_single();
    words = '{8'hA5};
    run_stream("single_a5", 2'b10, -1, -1);
    words = '{8'h07};
    run_stream("single_07", 2'b11, -1, -1);
    for (int i = 0; i < 3; i++) begin
      words = '{W'($urandom)};
      run_stream("single_rand", 2'b10 | 2'($urandom % 2), -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    words = '{8'h3C, 8'hF0};
    run_stream("b2b_3c_f0", 2'b10, -1, -1);
    words = '{W'($urandom), W'($urandom), W'($urandom)};
    run_stream("b2b_rand3", 2'b11, -1, -1);
  endtask

  task automatic test_ts_control();
    words = '{8'hFF};
    run_stream("ts_gap", 2'b01, 3, 4);
    words = '{8'hFF};
    run_stream("tsmux_hiz", 2'b00, -1, -1);
    words = '{W'($urandom), W'($urandom)};
    run_stream("ts_rand", 2'b01, int'($urandom % 8), 8 + int'($urandom % 6));
  endtask

  task automatic test_reset_mid_word();
    logic [1:0] o_pin;
    cfg_tsmux = 2'b01;
    ts = 1'b1;
    @(negedge clk);
    txif.txvalid = 1'b1;
    txif.txd     = 8'h55;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) txif.txd = 8'hC3;
    end
    #1;
    o_pin = pin_obs(pin_z, pin);
    checks++;
    if (o_pin !== 2'd1 || busy !== 1'b1 || txif.txready !== 1'b0) begin
      errors++;
      $display("FAIL mid_word_pre: got pin=%0d busy=%b ready=%b expected 1 1 0",
               o_pin, busy, txif.txready);
    end
    rst_n = 1'b0;
    txif.txvalid = 1'b0;
    #1;
    check_idle("mid_word_reset", 2'd2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      check_idle("post_reset_quiet", 2'd2);
    end
    cfg_tsmux = 2'b10;
    #1;
    check_idle("post_reset_drv", 2'd1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      int n;
      n = 1 + int'($urandom % 3);
      words = {};
      for (int i = 0; i < n; i++) words.push_back(W'($urandom));
      run_stream("random", 2'($urandom % 4), int'($urandom % 10), 10 + int'($urandom % 8));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ts_control();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
